// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM encoding, write-owner tag and
// default geometry.
package sram_arb_pkg;

    localparam int AW_DEF           = 19;
    localparam int STARVE_LIMIT_DEF = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VRD1,
        S_VRD2,
        S_CRD1,
        S_CRD2,
        S_WR1,
        S_WR2,
        S_WR3
    } arb_state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_LDR
    } wr_owner_e;

endpackage

// File: rtl/sram_arbiter.sv
// Single-port async SRAM shared by video fetch, Z80 and boot loader.
//   state | meaning
//   IDLE  | arbitrate; SRAM quiet
//   VRD1  | video read, address + OE
//   VRD2  | video read, sample data at end
//   CRD1  | CPU read, address + OE
//   CRD2  | CPU read, sample data at end
//   WR1   | write setup, data driven, WE high
//   WR2   | write strobe, WE low
//   WR3   | write hold, WE high, data driven
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_valid,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_mreq_n,
    input  logic          cpu_rd_n,
    input  logic          cpu_wr_n,
    input  logic          cpu_rfsh_n,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          cpu_wait_n,
    input  logic          ldr_req,
    input  logic [AW-1:0] ldr_addr,
    input  logic [7:0]    ldr_data,
    output logic          ldr_ack,
    output logic [AW-1:0] sram_a,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic [7:0]    sram_d_o,
    output logic          sram_d_oe,
    input  logic [7:0]    sram_d_i
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    wr_owner_e     owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          cpu_done_q, cpu_done_d;
    logic [7:0]    vid_data_q;
    logic          vid_valid_q;
    logic [7:0]    cpu_din_q;
    logic          ldr_ack_q;

    logic cpu_pend;
    logic ldr_starved;
    logic ldr_grant;

    assign cpu_pend    = !cpu_mreq_n && cpu_rfsh_n && (!cpu_rd_n || !cpu_wr_n) && !cpu_done_q;
    assign ldr_starved = (starve_q == STARVE_MAX);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ldr_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vid_req) begin
                    state_d = S_VRD1;
                    addr_d  = vid_addr;
                end else if (ldr_req && ldr_starved) begin
                    state_d   = S_WR1;
                    owner_d   = OWN_LDR;
                    addr_d    = ldr_addr;
                    wdata_d   = ldr_data;
                    ldr_grant = 1'b1;
                end else if (cpu_pend) begin
                    addr_d = cpu_addr;
                    if (!cpu_rd_n) begin
                        state_d = S_CRD1;
                    end else begin
                        state_d = S_WR1;
                        owner_d = OWN_CPU;
                        wdata_d = cpu_dout;
                    end
                end else if (ldr_req) begin
                    state_d   = S_WR1;
                    owner_d   = OWN_LDR;
                    addr_d    = ldr_addr;
                    wdata_d   = ldr_data;
                    ldr_grant = 1'b1;
                end
            end
            S_VRD1:  state_d = S_VRD2;
            S_VRD2:  state_d = S_IDLE;
            S_CRD1:  state_d = S_CRD2;
            S_CRD2:  state_d = S_IDLE;
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = S_WR3;
            S_WR3:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // MREQ going high always wins so a new Z80 cycle can never inherit a stale done.
    always_comb begin
        cpu_done_d = cpu_done_q;
        if (cpu_mreq_n) begin
            cpu_done_d = 1'b0;
        end else if (state_q == S_CRD2 || (state_q == S_WR3 && owner_q == OWN_CPU)) begin
            cpu_done_d = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!ldr_req || ldr_grant) begin
            starve_d = '0;
        end else if (!ldr_starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_CPU;
            addr_q      <= '0;
            wdata_q     <= '0;
            starve_q    <= '0;
            cpu_done_q  <= 1'b0;
            vid_data_q  <= 8'hFF;
            vid_valid_q <= 1'b0;
            cpu_din_q   <= 8'hFF;
            ldr_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            cpu_done_q  <= cpu_done_d;
            vid_valid_q <= (state_q == S_VRD2);
            ldr_ack_q   <= (state_q == S_WR3) && (owner_q == OWN_LDR);
            if (state_q == S_VRD2) vid_data_q <= sram_d_i;
            if (state_q == S_CRD2) cpu_din_q  <= sram_d_i;
        end
    end

    // Strobes decode straight from the state register so reset releases WE at once.
    assign sram_oe_n  = !(state_q inside {S_VRD1, S_VRD2, S_CRD1, S_CRD2});
    assign sram_we_n  = (state_q != S_WR2);
    assign sram_d_oe  = (state_q inside {S_WR1, S_WR2, S_WR3});
    assign sram_a     = addr_q;
    assign sram_d_o   = wdata_q;
    assign vid_data   = vid_data_q;
    assign vid_valid  = vid_valid_q;
    assign cpu_din    = cpu_din_q;
    assign ldr_ack    = ldr_ack_q;
    assign cpu_wait_n = !cpu_pend;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM plus a shadow memory that predicts
// every read, with directed priority/starvation/reset scenarios and random ops.
module tb_sram_arbiter;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_valid;
    logic [AW-1:0] cpu_addr;
    logic          cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n;
    logic [7:0]    cpu_dout;
    logic [7:0]    cpu_din;
    logic          cpu_wait_n;
    logic          ldr_req;
    logic [AW-1:0] ldr_addr;
    logic [7:0]    ldr_data;
    logic          ldr_ack;
    logic [AW-1:0] sram_a;
    logic          sram_we_n, sram_oe_n, sram_d_oe;
    logic [7:0]    sram_d_o;
    logic [7:0]    sram_d_i;

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_addr(cpu_addr), .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_rfsh_n(cpu_rfsh_n), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_wait_n(cpu_wait_n),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_ack(ldr_ack),
        .sram_a(sram_a), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe), .sram_d_i(sram_d_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural SRAM: 256 locations aliased on the low address byte.
    function automatic logic [7:0] init_byte(input logic [7:0] i);
        return i * 8'd37 + 8'd11;
    endfunction

    logic [7:0] pad_mem [256];
    bit         pad_written [256];
    logic [7:0] ref_mem [256];

    assign sram_d_i = pad_written[sram_a[7:0]] ? pad_mem[sram_a[7:0]] : init_byte(sram_a[7:0]);

    always @(negedge clk) begin
        if (rst_n && !sram_we_n) begin
            pad_mem[sram_a[7:0]]     <= sram_d_o;
            pad_written[sram_a[7:0]] <= 1'b1;
        end
    end

    // Bus monitor: access starts, pulses, strobe cycles, protocol violations.
    logic          act_now;
    logic          act_prev = 1'b0, doe_prev = 1'b0;
    logic [AW-1:0] a_prev = '0;
    logic [7:0]    d_prev = '0;
    logic [AW-1:0] acc_log [$];
    int acc_cnt = 0, vv_cnt = 0, ack_cnt = 0, we_low_cnt = 0, oe_low_cnt = 0;
    int excl_bad = 0, wr_unstable = 0;

    assign act_now = !sram_oe_n || sram_d_oe;

    always @(negedge clk) begin
        if (act_now && !act_prev) begin
            acc_cnt <= acc_cnt + 1;
            acc_log.push_back(sram_a);
        end
        if (vid_valid)  vv_cnt     <= vv_cnt + 1;
        if (ldr_ack)    ack_cnt    <= ack_cnt + 1;
        if (!sram_we_n) we_low_cnt <= we_low_cnt + 1;
        if (!sram_oe_n) oe_low_cnt <= oe_low_cnt + 1;
        if (!sram_we_n && !sram_oe_n) excl_bad <= excl_bad + 1;
        if (sram_d_oe && doe_prev && (sram_a !== a_prev || sram_d_o !== d_prev))
            wr_unstable <= wr_unstable + 1;
        act_prev <= act_now;
        doe_prev <= sram_d_oe;
        a_prev   <= sram_a;
        d_prev   <= sram_d_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vid_read(input logic [AW-1:0] a);
        int lat, n, vv0, oe0;
        vv0 = vv_cnt; oe0 = oe_low_cnt;
        vid_addr = a; vid_req = 1'b1; lat = 0;
        @(negedge clk);
        while (sram_oe_n && lat < 8) begin lat++; @(negedge clk); end
        vid_req = 1'b0;
        check_eq("vid_latency_le4", lat <= 4, 1'b1);
        check_eq("vid_addr", sram_a, a);
        n = 0;
        while (!vid_valid && n < 6) begin @(negedge clk); n++; end
        check_eq("vid_valid_seen", vid_valid, 1'b1);
        check_eq("vid_data", vid_data, ref_mem[a[7:0]]);
        tick(); tick();
        check_eq("vid_valid_once", vv_cnt - vv0, 1);
        check_eq("vid_oe_cycles", oe_low_cnt - oe0, 2);
    endtask

    task automatic cpu_read(input logic [AW-1:0] a);
        int n, acc0;
        acc0 = acc_cnt;
        cpu_addr = a; cpu_rd_n = 1'b0; cpu_mreq_n = 1'b0;
        #1;
        check_eq("cpu_rd_wait_low", cpu_wait_n, 1'b0);
        n = 0;
        @(negedge clk);
        while (!cpu_wait_n && n < 10) begin n++; @(negedge clk); end
        check_eq("cpu_rd_wait_cycles", n, 3);
        check_eq("cpu_din", cpu_din, ref_mem[a[7:0]]);
        repeat (3) tick();
        check_eq("cpu_rd_wait_held_hi", cpu_wait_n, 1'b1);
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        tick(); tick();
        check_eq("cpu_rd_single_access", acc_cnt - acc0, 1);
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        int n, we0, doe, bad;
        we0 = we_low_cnt; doe = 0; bad = 0; n = 0;
        cpu_addr = a; cpu_dout = d; cpu_wr_n = 1'b0; cpu_mreq_n = 1'b0;
        @(negedge clk);
        while (!cpu_wait_n && n < 12) begin
            if (sram_d_oe) begin
                doe++;
                if (sram_a !== a || sram_d_o !== d) bad++;
            end
            n++;
            @(negedge clk);
        end
        check_eq("cpu_wr_wait_cycles", n, 4);
        check_eq("cpu_wr_doe_cycles", doe, 3);
        check_eq("cpu_wr_addr_data", bad, 0);
        tick();
        cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
        tick();
        check_eq("cpu_wr_we_cycles", we_low_cnt - we0, 1);
        ref_mem[a[7:0]] = d;
    endtask

    task automatic ldr_write(input logic [AW-1:0] a, input logic [7:0] d, output int wait_cyc);
        int n, we0, ack0, doe, bad;
        we0 = we_low_cnt; ack0 = ack_cnt; doe = 0; bad = 0; n = 0; wait_cyc = -1;
        ldr_addr = a; ldr_data = d; ldr_req = 1'b1;
        @(negedge clk);
        while (!ldr_ack && n < 600) begin
            if (sram_d_oe) begin
                if (wait_cyc < 0) wait_cyc = n;
                doe++;
                if (sram_a !== a || sram_d_o !== d) bad++;
            end
            n++;
            @(negedge clk);
        end
        ldr_req = 1'b0;
        check_eq("ldr_ack_seen", ldr_ack, 1'b1);
        check_eq("ldr_doe_cycles", doe, 3);
        check_eq("ldr_addr_data", bad, 0);
        tick(); tick();
        check_eq("ldr_we_cycles", we_low_cnt - we0, 1);
        check_eq("ldr_ack_once", ack_cnt - ack0, 1);
        ref_mem[a[7:0]] = d;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, base, acc0, ack0, n;
        logic vd, cd, ld, hog_en, prev_oe;
        logic [7:0] got_v, got_c;
        logic [AW-1:0] ra;
        logic [7:0] rd;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(8'(i));

        rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
        cpu_addr = '0; cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        cpu_rfsh_n = 1'b1; cpu_dout = '0;
        ldr_req = 1'b0; ldr_addr = '0; ldr_data = '0;
        repeat (3) tick();

        check_eq("rst_oe_n", sram_oe_n, 1'b1);
        check_eq("rst_we_n", sram_we_n, 1'b1);
        check_eq("rst_d_oe", sram_d_oe, 1'b0);
        check_eq("rst_sram_a", sram_a, 0);
        check_eq("rst_sram_d_o", sram_d_o, 0);
        check_eq("rst_vid_data", vid_data, 8'hFF);
        check_eq("rst_cpu_din", cpu_din, 8'hFF);
        check_eq("rst_vid_valid", vid_valid, 1'b0);
        check_eq("rst_ldr_ack", ldr_ack, 1'b0);
        check_eq("rst_wait_n", cpu_wait_n, 1'b1);
        rst_n = 1'b1;
        tick(); tick();

        // Seed known bytes, then the basic read/write transactions.
        ldr_write(19'h00100, 8'h5A, w);
        check_eq("ldr_idle_wait", w, 1);
        vid_read(19'h00100);
        check_eq("vid_5a", vid_data, 8'h5A);
        ldr_write(19'h12345, 8'hC3, w);
        cpu_read(19'h12345);
        check_eq("cpu_c3", cpu_din, 8'hC3);
        cpu_write(19'h00010, 8'h7E);
        vid_read(19'h00010);
        check_eq("vid_7e", vid_data, 8'h7E);

        // Refresh cycles must never reach the SRAM.
        acc0 = acc_cnt;
        cpu_addr = 19'h00042; cpu_rfsh_n = 1'b0; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
        #1;
        check_eq("rfsh_wait_n", cpu_wait_n, 1'b1);
        repeat (5) tick();
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        tick();
        cpu_rfsh_n = 1'b1;
        tick();
        check_eq("rfsh_no_access", acc_cnt - acc0, 0);

        // Video, CPU and loader all request in the same clock.
        base = acc_log.size();
        vid_addr = 19'h00100; cpu_addr = 19'h12345; ldr_addr = 19'h0ABCD; ldr_data = 8'h3C;
        vid_req = 1'b1; ldr_req = 1'b1; cpu_rd_n = 1'b0; cpu_mreq_n = 1'b0;
        vd = 0; cd = 0; ld = 0; n = 0; got_v = '0; got_c = '0;
        while (!(vd && cd && ld) && n < 40) begin
            @(negedge clk);
            n++;
            if (vid_req && !sram_oe_n) vid_req = 1'b0;
            if (vid_valid) begin vd = 1; got_v = vid_data; end
            if (!cd && !cpu_mreq_n && cpu_wait_n) begin
                cd = 1; got_c = cpu_din; cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
            end
            if (ldr_ack) begin ld = 1; ldr_req = 1'b0; end
        end
        tick(); tick();
        check_eq("tri_all_done", {vd, cd, ld}, 3'b111);
        check_eq("tri_access_count", acc_log.size() - base, 3);
        check_eq("tri_first_video", acc_log[base], 19'h00100);
        check_eq("tri_second_cpu", acc_log[base + 1], 19'h12345);
        check_eq("tri_third_loader", acc_log[base + 2], 19'h0ABCD);
        check_eq("tri_vid_data", got_v, ref_mem[8'h00]);
        check_eq("tri_cpu_din", got_c, ref_mem[8'h45]);
        ref_mem[8'hCD] = 8'h3C;

        // Loader starvation under a CPU that requests at every arbitration slot.
        acc0 = acc_cnt;
        cpu_addr = 19'h00033; cpu_rd_n = 1'b0; cpu_mreq_n = 1'b0;
        hog_en = 1'b1; prev_oe = 1'b0;
        fork
            begin
                ldr_write(19'h00055, 8'hA7, w);
                hog_en = 1'b0;
            end
            begin
                while (hog_en) begin
                    @(negedge clk);
                    cpu_mreq_n = !sram_oe_n && prev_oe;
                    prev_oe = !sram_oe_n;
                end
            end
        join
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        repeat (5) tick();
        check_eq("starve_not_early", w >= 256, 1'b1);
        check_eq("starve_not_late", w <= 258, 1'b1);
        check_eq("starve_cpu_busy", (acc_cnt - acc0) > 60, 1'b1);
        vid_read(19'h00055);

        // Random transactions against the shadow memory.
        for (int k = 0; k < 40; k++) begin
            ra = AW'($urandom);
            rd = 8'($urandom);
            case ($urandom_range(0, 3))
                0: vid_read(ra);
                1: cpu_read(ra);
                2: cpu_write(ra, rd);
                default: begin
                    ldr_write(ra, rd, w);
                    check_eq("rnd_ldr_wait", w, 1);
                end
            endcase
        end

        // Reset in the middle of a loader write strobe.
        ack0 = ack_cnt;
        ldr_addr = 19'h00077; ldr_data = 8'h99; ldr_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (sram_we_n && n < 10) begin n++; @(negedge clk); end
        check_eq("rst_wr2_reached", sram_we_n, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstwr_we_n", sram_we_n, 1'b1);
        check_eq("rstwr_d_oe", sram_d_oe, 1'b0);
        check_eq("rstwr_oe_n", sram_oe_n, 1'b1);
        check_eq("rstwr_sram_a", sram_a, 0);
        check_eq("rstwr_vid_data", vid_data, 8'hFF);
        check_eq("rstwr_cpu_din", cpu_din, 8'hFF);
        ldr_req = 1'b0;
        ref_mem[8'h77] = 8'h99;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("rstwr_no_ack", ack_cnt - ack0, 0);
        check_eq("rstwr_idle_oe", sram_oe_n, 1'b1);
        check_eq("rstwr_idle_doe", sram_d_oe, 1'b0);
        vid_read(19'h00010);

        check_eq("we_oe_exclusive", excl_bad, 0);
        check_eq("write_bus_stable", wr_unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, 19, SRAM address width.
REQ-002 Parameter STARVE_LIMIT, 255, loader wait cycles before it outranks CPU.
REQ-003 Ports, in this order:
- clk  in  1  system clock; one clock domain, no other clocks.
- rst_n  in  1  asynchronous active-low reset.
- vid_req  in  1  video fetch request (level).
- vid_addr  in  AW  video fetch address.
- vid_data  out  8  captured video byte.
- vid_valid  out  1  one-clock pulse; vid_data valid.
- cpu_addr  in  AW  Z80 address.
- cpu_mreq_n  in  1  Z80 memory request.
- cpu_rd_n  in  1  Z80 read strobe.
- cpu_wr_n  in  1  Z80 write strobe.
- cpu_rfsh_n  in  1  Z80 refresh.
- cpu_dout  in  8  data from CPU.
- cpu_din  out  8  data to CPU, held until next CPU read.
- cpu_wait_n  out  1  Z80 wait line.
- ldr_req  in  1  boot loader write request (level).
- ldr_addr  in  AW  loader address.
- ldr_data  in  8  loader byte.
- ldr_ack  out  1  one-clock pulse; write complete.
- sram_a  out  AW  SRAM address.
- sram_we_n  out  1  SRAM write enable.
- sram_oe_n  out  1  SRAM output enable.
- sram_d_o  out  8  write data to pad.
- sram_d_oe  out  1  pad drive enable.
- sram_d_i  in  8  read data from pad.

Function
REQ-004 FSM states: IDLE, VRD1, VRD2, CRD1, CRD2, WR1, WR2, WR3; arbitration occurs only in IDLE.
REQ-005 CPU access pending = cpu_mreq_n=0, cpu_rfsh_n=1, (cpu_rd_n=0 or cpu_wr_n=0), cpu_done=0; refresh cycles never reach SRAM.
REQ-006 Priority in IDLE: vid_req > loader if starve count = STARVE_LIMIT > pending CPU > ldr_req; nothing pending -> stay IDLE, sram_oe_n=1, sram_we_n=1, sram_d_oe=0.
REQ-007 Read: VRD1/CRD1 drive address with sram_oe_n=0; VRD2/CRD2 keep it and sample sram_d_i at end of state; next state IDLE.
REQ-008 Video read: vid_data loaded and vid_valid=1 for the clock after VRD2; exactly one vid_valid per grant.
REQ-009 CPU read: cpu_din loaded at end of CRD2; cpu_done set.
REQ-010 Write (CPU or loader, owner latched in IDLE): WR1 address+data, sram_d_oe=1, we_n=1; WR2 we_n=0; WR3 we_n=1, data still driven; then IDLE.
REQ-011 Address and data held constant across WR1-WR3 (latched on grant); sram_we_n never low outside WR2.
REQ-012 CPU write sets cpu_done at end of WR3; loader write pulses ldr_ack in the clock after WR3.
REQ-013 cpu_done clears when cpu_mreq_n=1; at most one SRAM access per Z80 MREQ cycle.
REQ-014 cpu_wait_n combinational: 0 while CPU access pending and not done, else 1.
REQ-015 Starve counter: increments each clock ldr_req=1 and not granted, saturates at STARVE_LIMIT, clears on loader grant or ldr_req=0.
REQ-016 Maximum video grant latency 3 clocks from vid_req rising in any state.
REQ-017 Simultaneous vid_req, CPU and ldr_req in IDLE: video, then CPU, then loader (starve count below limit).

Reset
REQ-018 rst_n=0 asynchronously forces IDLE, sram_we_n=1, sram_oe_n=1, sram_d_oe=0, sram_a=0, sram_d_o=0, vid_data=FF, cpu_din=FF, vid_valid=0, ldr_ack=0, cpu_done=0, starve count 0.
REQ-019 Reset during WR2 deasserts sram_we_n immediately; the interrupted write is not acknowledged.

Structure
REQ-020 Shared package sram_arb_pkg holds state encoding, AW and STARVE_LIMIT defaults.
REQ-021 Single module; no sub-module warranted.

Verification
REQ-022 vid_req=1, vid_addr=0x00100, sram_d_i=0x5A -> sram_oe_n=0 two clocks, vid_valid one clock later with vid_data=0x5A.
REQ-023 CPU read addr 0x12345 with sram_d_i=0xC3 -> cpu_wait_n low until CRD2 ends, cpu_din=0xC3, no second access while mreq_n stays low.
REQ-024 CPU write 0x7E to 0x00010 -> we_n low exactly one clock (WR2), sram_d_o=0x7E and sram_a=0x00010 for WR1-WR3.
REQ-025 ldr_req held with CPU accessing every cycle -> loader granted after 255 waiting clocks, ldr_ack pulses once.
REQ-026 All three requesters assert same clock -> grant order video, CPU, loader; refresh cycle (rfsh_n=0) produces no SRAM access.
REQ-027 rst_n low during WR2 -> sram_we_n=1 same time step, no ldr_ack, FSM IDLE after release.
